// File: rtl/spi_pkg.sv
// Shared definitions for the Quad-SPI transmit serializer: FSM state
// encoding, I/O mode constants, the transaction byte limit and the small
// helpers that map a mode onto lane width and pad enables.
package spi_pkg;

  localparam int unsigned CNT_W     = 9;
  localparam int unsigned MAX_BYTES = 261;
  localparam int unsigned DIV_W     = 8;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_DUAL   = 2'b01;
  localparam logic [1:0] MODE_QUAD   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Data lines driven per SCK period; the reserved mode 11 behaves as single.
  function automatic logic [2:0] bits_per_sck(input logic [1:0] mode);
    case (mode)
      MODE_DUAL: return 3'd2;
      MODE_QUAD: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  // Index of the final SCK period of a byte (8/W - 1).
  function automatic logic [2:0] last_sym(input logic [1:0] mode);
    case (mode)
      MODE_DUAL: return 3'd3;
      MODE_QUAD: return 3'd1;
      default:   return 3'd7;
    endcase
  endfunction

  function automatic logic [3:0] io_oe_for(input logic [1:0] mode);
    case (mode)
      MODE_DUAL: return 4'b0011;
      MODE_QUAD: return 4'b1111;
      default:   return 4'b0001;
    endcase
  endfunction

  // Map the top nibble of the shift register onto the pads; unused lines are 0.
  function automatic logic [3:0] io_map(input logic [3:0] top, input logic [1:0] mode);
    case (mode)
      MODE_DUAL: return {2'b00, top[3:2]};
      MODE_QUAD: return top;
      default:   return {3'b000, top[3]};
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_transmit_if.sv
// Bus bundle between the transmit serializer, its request source, the
// transmit FIFO read port and the flash pad logic.
//   master : request/FIFO side (drives start, byte_cnt, mode, fifo_*)
//   slave  : serializer side (drives fifo_rd_en and the SPI/status outputs)
interface spi_shift_transmit_if;
  import spi_pkg::*;

  logic             start;
  logic [CNT_W-1:0] byte_cnt;
  logic [1:0]       mode;
  logic [7:0]       fifo_data;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             sck;
  logic             cs_n;
  logic [3:0]       io_out;
  logic [3:0]       io_oe;
  logic             busy;
  logic             done;
  logic             underrun;

  modport master (
    output start, byte_cnt, mode, fifo_data, fifo_empty,
    input  fifo_rd_en, sck, cs_n, io_out, io_oe, busy, done, underrun
  );

  modport slave (
    input  start, byte_cnt, mode, fifo_data, fifo_empty,
    output fifo_rd_en, sck, cs_n, io_out, io_oe, busy, done, underrun
  );

endinterface

// File: rtl/spi_sck_div.sv
// SCK generator: half-period counter of CLK_DIV cycles.
//   clk, reset : system clock, synchronous active-high reset
//   i_load     : hold counter at zero and SCK low
//   i_en       : run the counter
//   o_rise_c   : strobe in the cycle whose edge raises SCK
//   o_fall_c   : strobe in the cycle whose edge lowers SCK
//   o_sck      : registered SCK level
module spi_sck_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_rise_c,
  output logic o_fall_c,
  output logic o_sck
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sck;
  logic             w_expire;

  assign w_expire = i_en && !i_load && (r_cnt == LAST);
  assign o_rise_c = w_expire && !r_sck;
  assign o_fall_c = w_expire &&  r_sck;
  assign o_sck    = r_sck;

  always_ff @(posedge clk) begin
    if (reset || i_load) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (i_en) begin
      if (w_expire) begin
        r_cnt <= '0;
        r_sck <= ~r_sck;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_shift_transmit.sv
// Quad-SPI transmit serializer: pops bytes from a show-ahead FIFO and shifts
// them MSB-first in single/dual/quad mode with SPI mode-0 SCK and CS_n.
//   clk, reset : system clock, synchronous active-high reset
//   bus.slave  : start/byte_cnt/mode request, FIFO read port (fifo_rd_en is
//                the only combinational output), sck/cs_n/io_out/io_oe pads,
//                busy/done/underrun status
module spi_shift_transmit
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_shift_transmit_if.slave  bus
);

  localparam logic [DIV_W-1:0] FIN_LAST = DIV_W'(CLK_DIV - 1);

  state_t           r_state,    w_state_nxt;
  logic [7:0]       r_sr,       w_sr_nxt;
  logic [1:0]       r_mode,     w_mode_nxt;
  logic [CNT_W-1:0] r_remain,   w_remain_nxt;
  logic [2:0]       r_sym,      w_sym_nxt;
  logic [DIV_W-1:0] r_fin_cnt,  w_fin_cnt_nxt;
  logic             r_cs_n,     w_cs_n_nxt;
  logic [3:0]       r_io_out,   w_io_out_nxt;
  logic [3:0]       r_io_oe,    w_io_oe_nxt;
  logic             r_busy,     w_busy_nxt;
  logic             r_done,     w_done_nxt;
  logic             r_underrun, w_underrun_nxt;

  logic [CNT_W-1:0] w_req_cnt;
  logic [7:0]       w_sr_shift;
  logic             w_pop;
  logic             w_rise;
  logic             w_fall;
  logic             w_sck;

  // Requests above one page program transaction are clamped.
  assign w_req_cnt  = (bus.byte_cnt > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : bus.byte_cnt;
  assign w_sr_shift = r_sr << bits_per_sck(r_mode);
  assign w_pop      = (r_state == ST_LOAD) && !bus.fifo_empty;

  // Divider is held low outside SHIFT, which stretches SCK low over LOAD.
  spi_sck_div #(.CLK_DIV(CLK_DIV)) u_sck_div (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state != ST_SHIFT),
    .i_en     (r_state == ST_SHIFT),
    .o_rise_c (w_rise),
    .o_fall_c (w_fall),
    .o_sck    (w_sck)
  );

  // State and registered-output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sr       <= '0;
      r_mode     <= MODE_SINGLE;
      r_remain   <= '0;
      r_sym      <= '0;
      r_fin_cnt  <= '0;
      r_cs_n     <= 1'b1;
      r_io_out   <= '0;
      r_io_oe    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sr       <= w_sr_nxt;
      r_mode     <= w_mode_nxt;
      r_remain   <= w_remain_nxt;
      r_sym      <= w_sym_nxt;
      r_fin_cnt  <= w_fin_cnt_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_io_out   <= w_io_out_nxt;
      r_io_oe    <= w_io_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_sr_nxt       = r_sr;
    w_mode_nxt     = r_mode;
    w_remain_nxt   = r_remain;
    w_sym_nxt      = r_sym;
    w_fin_cnt_nxt  = r_fin_cnt;
    w_cs_n_nxt     = r_cs_n;
    w_io_out_nxt   = r_io_out;
    w_io_oe_nxt    = r_io_oe;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_underrun_nxt = r_underrun;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_underrun_nxt = 1'b0;
          if (w_req_cnt == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_LOAD;
            w_cs_n_nxt   = 1'b0;
            w_busy_nxt   = 1'b1;
            w_mode_nxt   = bus.mode;
            w_remain_nxt = w_req_cnt;
          end
        end
      end

      ST_LOAD: begin
        if (w_pop) begin
          w_sr_nxt     = bus.fifo_data;
          w_io_out_nxt = io_map(bus.fifo_data[7:4], r_mode);
          w_io_oe_nxt  = io_oe_for(r_mode);
          w_sym_nxt    = '0;
          w_state_nxt  = ST_SHIFT;
        end else begin
          // Stall with SCK low until the FIFO refills.
          w_underrun_nxt = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (w_fall) begin
          if (r_sym == last_sym(r_mode)) begin
            w_remain_nxt = r_remain - 1'b1;
            if (r_remain == CNT_W'(1)) begin
              w_state_nxt   = ST_FINISH;
              w_fin_cnt_nxt = '0;
              w_io_oe_nxt   = '0;
              w_io_out_nxt  = '0;
            end else begin
              w_state_nxt = ST_LOAD;
            end
          end else begin
            w_sr_nxt     = w_sr_shift;
            w_io_out_nxt = io_map(w_sr_shift[7:4], r_mode);
            w_sym_nxt    = r_sym + 1'b1;
          end
        end
      end

      ST_FINISH: begin
        if (r_fin_cnt == FIN_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cs_n_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_fin_cnt_nxt = r_fin_cnt + 1'b1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.fifo_rd_en = w_pop;
  assign bus.sck        = w_sck;
  assign bus.cs_n       = r_cs_n;
  assign bus.io_out     = r_io_out;
  assign bus.io_oe      = r_io_oe;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.underrun   = r_underrun;

endmodule

// File: doc/spi_shift_transmit.md
# spi_shift_transmit

Transmit serializer for the Quad-SPI core: drains bytes from the transmit byte FIFO (show-ahead read port) and shifts them MSB-first onto the flash I/O lines in single, dual or quad mode. It generates SCK (SPI mode 0) and CS_n for one transaction of up to 261 bytes (command + 3 address + 256-byte page + 1). It is the outbound counterpart of the receive FIFO path and sits between the transmit FIFO and the I/O pad logic.

## Interface
- CLK_DIV, 2: SCK half-period in clk cycles; legal range 1–255.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- byte_cnt  in  9  bytes to send, 0–261; latched on accepted start.
- mode  in  2  00 single, 01 dual, 10 quad, 11 treated as single; latched on accepted start.
- fifo_data  in  8  FIFO head byte, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe, one cycle per byte consumed.
- sck  out  1  serial clock; idles low.
- cs_n  out  1  chip select, active low.
- io_out  out  4  serial data; unused bits driven 0.
- io_oe  out  4  per-line output enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of transaction.
- underrun  out  1  sticky; set when the FIFO is empty at a byte load; cleared by an accepted start or reset.

## Operation
- States: IDLE, LOAD, SHIFT, FINISH.
- IDLE: cs_n=1, sck=0, io_oe=0, io_out=0. Accepted start with byte_cnt≠0 → LOAD. Accepted start with byte_cnt=0 → done pulse next cycle, cs_n stays high.
- LOAD: cs_n=0, sck=0. fifo_rd_en = (state==LOAD && !fifo_empty), combinational. If not empty, capture fifo_data into an 8-bit shift register → SHIFT. If empty, stay in LOAD with SCK held low, set underrun, and wait (stall, not abort).
- SHIFT: half-period counter counts CLK_DIV cycles. SCK toggles at each expiry. On each SCK falling edge, shift left by width W (1/2/4). After 8/W SCK periods: decrement remaining count. Nonzero → LOAD; zero → FINISH.
- Output mapping: single io_out[0]=sr[7], io_oe=0001. Dual io_out[1:0]=sr[7:6], io_oe=0011. Quad io_out[3:0]=sr[7:4], io_oe=1111.
- FINISH: sck=0, cs_n=0 for CLK_DIV cycles, then → IDLE with cs_n=1 and done=1 for one cycle. io_oe drops to 0 on entry to FINISH.
- start while busy is ignored. byte_cnt>261 is clamped to 261.
- reset in any state: next cycle all outputs are at their IDLE values, done=0, underrun=0, fifo_rd_en=0.

## Timing
- Start accepted at cycle 0 → cs_n low and first fifo_rd_en in cycle 1 (FIFO non-empty) → io_out valid from cycle 2 → first SCK rise at cycle 2+CLK_DIV.
- Data changes only while SCK is low. The slave samples on the SCK rising edge.
- Per-byte cost: 2·CLK_DIV·(8/W) + 1 cycles. The +1 is the LOAD cycle; SCK is stretched low during it.
- Transaction length with no stalls: 1 + N·(2·CLK_DIV·8/W + 1) + CLK_DIV cycles from start to done.
- Registered outputs: sck, cs_n, io_out, io_oe, busy, done, underrun. Only fifo_rd_en is combinational.

## Structure
- Shared package spi_pkg holds:
  - state encoding;
  - mode constants MODE_SINGLE/DUAL/QUAD;
  - MAX_BYTES=261;
  - width function bits_per_sck(mode).
- One sub-module, spi_sck_div: half-period counter with load/enable. It outputs a rise/fall strobe and the SCK level.

## Test plan
- Single mode, CLK_DIV=2, byte_cnt=1, FIFO={0xA5}: io_out[0] shows 1,0,1,0,0,1,0,1 at 8 SCK rises; done at cycle 1+1·33+2=36; one fifo_rd_en.
- Quad mode, byte_cnt=3, FIFO={0x12,0x34,0x56}: nibbles 1,2,3,4,5,6 on io_out at successive rises; io_oe=1111 throughout SHIFT; three fifo_rd_en pulses.
- Dual mode, FIFO empty for 10 cycles after start, then 0xC3 pushed: SCK stays low and cs_n stays 0 during the stall, underrun=1; then pairs 11,00,00,11 on io_out[1:0].
- byte_cnt=0: done pulses at cycle 1, cs_n never low, no fifo_rd_en.
- Reset asserted mid-SHIFT of the 2nd byte: next cycle cs_n=1, sck=0, io_oe=0, busy=0. A new start then sends from the current FIFO head.
- start pulsed while busy, and byte_cnt=300 on a later start: the busy start is ignored; the 300 request sends exactly 261 bytes, 261 fifo_rd_en pulses.
